serial_link_txrx: RTL and testbench

//  Parametrised async serial transceiver: TX serialises parallel words onto SERIAL_OUT, RX deserialises SERIAL_IN into a FIFO.

---
 rtl/serial_link_txrx.sv | 200 ++++++++++++++++++++
 tb/tb_serial_link_txrx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_txrx.sv
// serial_link_txrx: asynchronous serial transceiver with an RX FIFO.
//   TX : serialises TX_DATA onto SERIAL_OUT (start, data LSB first,
//        optional parity, STOP_BITS stop bits), one bit per CLKS_PER_BIT.
//   RX : 2-flop synchronised line (SERIAL_IN, or SERIAL_OUT in loopback),
//        centre-sampled, framing/parity checked, clean words pushed to FIFO.
// Ports
//   M_CLOCK, M_RESET_N                 clock, async active-low reset
//   TX_DATA/TX_VALID/TX_READY          parallel word in, accepted when idle
//   SERIAL_OUT, SERIAL_IN, LOOPBACK    serial line out/in, internal loopback
//   RX_DATA/RX_VALID/RX_READY          FIFO head, non-empty flag, pop strobe
//   FRAME_ERR, PARITY_ERR              1-cycle error pulses at stop sample
//   OVERFLOW, ERR_CLR                  sticky drop flag and its clear
module serial_link_txrx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              M_CLOCK,
  input  logic              M_RESET_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              SERIAL_OUT,
  input  logic              SERIAL_IN,
  input  logic              LOOPBACK,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic              FRAME_ERR,
  output logic              PARITY_ERR,
  output logic              OVERFLOW,
  input  logic              ERR_CLR
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_END = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_END = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t              tx_state, tx_next;
  logic [CW-1:0]       tx_cnt;
  logic [3:0]          tx_idx;
  logic [DATA_W-1:0]   tx_shr;
  logic                tx_par;
  logic                tx_tick;

  assign tx_tick  = (tx_cnt == BIT_END);
  assign TX_READY = (tx_state == S_IDLE);

  always_ff @(posedge M_CLOCK or negedge M_RESET_N)
    if (!M_RESET_N) tx_state <= S_IDLE;
    else            tx_state <= tx_next;

  always_comb begin
    tx_next    = tx_state;
    SERIAL_OUT = 1'b1;
    case (tx_state)
      S_IDLE:  if (TX_VALID) tx_next = S_START;
      S_START: begin
        SERIAL_OUT = 1'b0;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        SERIAL_OUT = tx_shr[0];
        if (tx_tick && tx_idx == DATA_END) tx_next = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        SERIAL_OUT = tx_par;
        if (tx_tick) tx_next = S_STOP;
      end
      S_STOP:  if (tx_tick && tx_idx == STOP_END) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  // Word and parity are captured at accept so TX_DATA may change while busy.
  always_ff @(posedge M_CLOCK or negedge M_RESET_N)
    if (!M_RESET_N) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_shr <= '0;
      tx_par <= 1'b0;
    end else if (tx_state == S_IDLE) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      if (TX_VALID) begin
        tx_shr <= TX_DATA;
        tx_par <= (PARITY == 2) ? ~^TX_DATA : ^TX_DATA;
      end
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_state == S_DATA) begin
        tx_shr <= tx_shr >> 1;
        tx_idx <= (tx_idx == DATA_END) ? 4'd0 : tx_idx + 4'd1;
      end else if (tx_state == S_STOP) begin
        tx_idx <= tx_idx + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end

  // ---------------- receiver ----------------
  logic [1:0]        sync_pipe;
  logic              rx_line;
  state_t            rx_state, rx_next;
  logic [CW-1:0]     rx_cnt;
  logic [3:0]        rx_idx;
  logic [DATA_W-1:0] rx_shr;
  logic              rx_pbit;
  logic              rx_tick, rx_half, stop_sample, par_bad, push;

  always_ff @(posedge M_CLOCK or negedge M_RESET_N)
    if (!M_RESET_N) sync_pipe <= 2'b11;
    else            sync_pipe <= {sync_pipe[0], LOOPBACK ? SERIAL_OUT : SERIAL_IN};

  assign rx_line = sync_pipe[1];
  assign rx_tick = (rx_cnt == BIT_END);
  assign rx_half = (rx_cnt == HALF_END);

  always_ff @(posedge M_CLOCK or negedge M_RESET_N)
    if (!M_RESET_N) rx_state <= S_IDLE;
    else            rx_state <= rx_next;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (!rx_line) rx_next = S_START;
      // Half-bit recheck rejects glitches shorter than half a bit.
      S_START: if (rx_half) rx_next = rx_line ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_idx == DATA_END) rx_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (rx_tick) rx_next = S_STOP;
      // Only the first stop bit is checked; re-arm straight after its sample.
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  // Counter restarts at the half-bit point so later samples land mid-bit.
  always_ff @(posedge M_CLOCK or negedge M_RESET_N)
    if (!M_RESET_N) begin
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_shr  <= '0;
      rx_pbit <= 1'b0;
    end else begin
      if (rx_state == S_IDLE || (rx_state == S_START && rx_half) || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == S_IDLE) rx_idx <= '0;
      if (rx_state == S_DATA && rx_tick) begin
        rx_shr <= {rx_line, rx_shr[DATA_W-1:1]};
        rx_idx <= (rx_idx == DATA_END) ? 4'd0 : rx_idx + 4'd1;
      end
      if (rx_state == S_PAR && rx_tick) rx_pbit <= rx_line;
    end

  assign stop_sample = (rx_state == S_STOP) && rx_tick;
  assign par_bad     = (PARITY == 0) ? 1'b0 :
                       (PARITY == 1) ? (rx_pbit != ^rx_shr) : (rx_pbit != ~^rx_shr);
  assign FRAME_ERR   = stop_sample && !rx_line;
  assign PARITY_ERR  = stop_sample && par_bad;
  assign push        = stop_sample && rx_line && !par_bad;

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, wr_en, ovf_set;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && RX_READY;
  // A pop in the same cycle frees the slot, so full+push+pop is legal.
  assign wr_en    = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign RX_VALID = !empty;
  assign RX_DATA  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge M_CLOCK or negedge M_RESET_N)
    if (!M_RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      OVERFLOW <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= rx_shr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)      OVERFLOW <= 1'b1;
      else if (ERR_CLR) OVERFLOW <= 1'b0;
    end

endmodule

// File: tb/tb_serial_link_txrx.sv
// Bench for serial_link_txrx: two instances at CLKS_PER_BIT=4
// (dut0: no parity, dut1: even parity). A frame-level model predicts every
// SERIAL_OUT cycle, TX_READY, the RX word stream and error pulse counts.
module tb_serial_link_txrx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data [2];
  logic       tx_valid [2], tx_ready [2], sout [2], sin [2], lb [2];
  logic [7:0] rx_data [2];
  logic       rx_valid [2], rx_ready [2], ferr [2], perr [2], ovf [2], eclr [2];

  serial_link_txrx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d0 (
    .M_CLOCK(clk), .M_RESET_N(rst_n), .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]),
    .TX_READY(tx_ready[0]), .SERIAL_OUT(sout[0]), .SERIAL_IN(sin[0]), .LOOPBACK(lb[0]),
    .RX_DATA(rx_data[0]), .RX_VALID(rx_valid[0]), .RX_READY(rx_ready[0]),
    .FRAME_ERR(ferr[0]), .PARITY_ERR(perr[0]), .OVERFLOW(ovf[0]), .ERR_CLR(eclr[0]));

  serial_link_txrx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d1 (
    .M_CLOCK(clk), .M_RESET_N(rst_n), .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]),
    .TX_READY(tx_ready[1]), .SERIAL_OUT(sout[1]), .SERIAL_IN(sin[1]), .LOOPBACK(lb[1]),
    .RX_DATA(rx_data[1]), .RX_VALID(rx_valid[1]), .RX_READY(rx_ready[1]),
    .FRAME_ERR(ferr[1]), .PARITY_ERR(perr[1]), .OVERFLOW(ovf[1]), .ERR_CLR(eclr[1]));

  int checks = 0, failures = 0;

  // model state
  bit         txexp [2][1024];
  int         tx_head [2], tx_tail [2];
  logic [7:0] rxexp [2][64];
  int         rx_head [2], rx_tail [2];
  int         exp_ferr [2], exp_perr [2], act_ferr [2], act_perr [2];
  logic       exp_ovf [2];
  logic       ferr_q [2], perr_q [2];
  logic [7:0] last_pop [2];
  logic [7:0] pop_log [16];
  int         pop_n = 0;
  bit         cap [64];
  int         cap_n = 0, cap_d = 0;
  bit         cap_en = 0, cap_req = 0, run = 0;
  logic       e_bit, busy;

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_rx_push(int d, logic [7:0] w);
    if (rx_tail[d] - rx_head[d] >= 4) exp_ovf[d] = 1'b1;
    else begin
      rxexp[d][rx_tail[d] % 64] = w;
      rx_tail[d]++;
    end
  endtask

  // Expected line waveform for one frame: start, data LSB first,
  // even parity on dut1, one stop bit; each bit lasts CPB cycles.
  task automatic model_tx(int d, logic [7:0] w);
    bit fb [12];
    int nb;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = w[i];
    nb = 9;
    if (d == 1) begin fb[9] = ^w; nb = 10; end
    fb[nb] = 1'b1;
    nb++;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < CPB; k++) begin
        txexp[d][tx_tail[d] % 1024] = fb[i];
        tx_tail[d]++;
      end
    if (lb[d]) model_rx_push(d, w);
  endtask

  task automatic send(int d, logic [7:0] w);
    int t = 0;
    while (!tx_ready[d] && t < 300) begin tick(1); t++; end
    chk("tx_ready_wait", d, 32'(tx_ready[d]), 32'd1);
    tx_data[d]  = w;
    tx_valid[d] = 1'b1;
    @(posedge clk);
    model_tx(d, w);
    if (cap_req) begin cap_n = 0; cap_d = d; cap_en = 1; cap_req = 0; end
    #1;
    tx_valid[d] = 1'b0;
    tx_data[d]  = ~w;   // must not disturb the frame in flight
  endtask

  // Drive a frame on SERIAL_IN; the model decides the outcome from the bits.
  task automatic inject(int d, logic [7:0] w, bit flip, bit stopv);
    bit fb [12];
    int nb;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = w[i];
    nb = 9;
    if (d == 1) begin fb[9] = (^w) ^ flip; nb = 10; end
    fb[nb] = stopv;
    nb++;
    if (!stopv) exp_ferr[d]++;
    if (d == 1 && flip) exp_perr[d]++;
    if (stopv && !(d == 1 && flip)) model_rx_push(d, w);
    for (int i = 0; i < nb; i++) begin sin[d] = fb[i]; tick(CPB); end
    sin[d] = 1'b1;
    tick(3 * CPB);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && run) begin
      for (int d = 0; d < 2; d++) begin
        busy = (tx_head[d] != tx_tail[d]);
        if (busy) begin e_bit = txexp[d][tx_head[d] % 1024]; tx_head[d]++; end
        else e_bit = 1'b1;
        chk("serial_out", d, 32'(sout[d]), 32'(e_bit));
        chk("tx_ready", d, 32'(tx_ready[d]), 32'(!busy));
        if (ferr[d]) act_ferr[d]++;
        if (perr[d]) act_perr[d]++;
        chk("frame_err_width", d, 32'(ferr[d] & ferr_q[d]), 32'd0);
        chk("parity_err_width", d, 32'(perr[d] & perr_q[d]), 32'd0);
        ferr_q[d] = ferr[d];
        perr_q[d] = perr[d];
        if (rx_valid[d] && rx_ready[d]) begin
          if (rx_head[d] == rx_tail[d]) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected_word dut%0d actual=%0h required=none", d, rx_data[d]);
          end else begin
            chk("rx_data", d, 32'(rx_data[d]), 32'(rxexp[d][rx_head[d] % 64]));
            rx_head[d]++;
          end
          last_pop[d] = rx_data[d];
          if (d == 0 && pop_n < 16) begin pop_log[pop_n] = rx_data[d]; pop_n++; end
        end
      end
      if (cap_en && cap_n < 64) begin cap[cap_n] = sout[cap_d]; cap_n++; end
    end
  end

  bit a5_bits [10] = '{0,1,0,1,0,0,1,0,1,1};
  logic [7:0] ovf_words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    for (int d = 0; d < 2; d++) begin
      tx_data[d] = '0; tx_valid[d] = 0; sin[d] = 1; lb[d] = 1; rx_ready[d] = 1; eclr[d] = 0;
      tx_head[d] = 0; tx_tail[d] = 0; rx_head[d] = 0; rx_tail[d] = 0;
      exp_ferr[d] = 0; exp_perr[d] = 0; act_ferr[d] = 0; act_perr[d] = 0;
      exp_ovf[d] = 0; ferr_q[d] = 0; perr_q[d] = 0; last_pop[d] = '0;
    end
    tick(3);
    // reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_serial_out", d, 32'(sout[d]), 32'd1);
      chk("rst_tx_ready", d, 32'(tx_ready[d]), 32'd1);
      chk("rst_rx_valid", d, 32'(rx_valid[d]), 32'd0);
      chk("rst_rx_data", d, 32'(rx_data[d]), 32'd0);
      chk("rst_errs", d, {29'd0, ferr[d], perr[d], ovf[d]}, 32'd0);
    end
    rst_n = 1'b1;
    run   = 1;
    tick(2);

    // A5 in loopback: literal line bits at mid-bit
    cap_req = 1;
    send(0, 8'hA5);
    tick(60);
    cap_en = 0;
    for (int k = 0; k < 10; k++) chk("a5_line_bit", 0, 32'(cap[k*CPB+2]), 32'(a5_bits[k]));
    chk("a5_rx_word", 0, 32'(last_pop[0]), 32'h0A5);
    chk("a5_drained", 0, 32'(rx_valid[0]), 32'd0);

    // 07 with even parity: parity bit literal 1
    cap_req = 1;
    send(1, 8'h07);
    tick(60);
    cap_en = 0;
    chk("p07_parity_bit", 1, 32'(cap[9*CPB+2]), 32'd1);
    chk("p07_rx_word", 1, 32'(last_pop[1]), 32'h07);

    // flipped parity on SERIAL_IN
    lb[1] = 0;
    inject(1, 8'h07, 1'b1, 1'b1);
    chk("perr_count", 1, 32'(act_perr[1]), 32'(exp_perr[1]));
    chk("perr_literal", 1, 32'(act_perr[1]), 32'd1);
    chk("perr_no_word", 1, 32'(rx_valid[1]), 32'd0);
    chk("perr_no_ferr", 1, 32'(act_ferr[1]), 32'd0);

    // stop bit forced low
    lb[0] = 0;
    inject(0, 8'h3C, 1'b0, 1'b0);
    chk("ferr_count", 0, 32'(act_ferr[0]), 32'(exp_ferr[0]));
    chk("ferr_literal", 0, 32'(act_ferr[0]), 32'd1);
    chk("ferr_no_word", 0, 32'(rx_valid[0]), 32'd0);

    // single-cycle glitch, then a clean external frame
    sin[0] = 1'b0;
    tick(1);
    sin[0] = 1'b1;
    tick(20);
    chk("glitch_no_word", 0, 32'(rx_valid[0]), 32'd0);
    chk("glitch_no_ferr", 0, 32'(act_ferr[0]), 32'd1);
    inject(0, 8'h96, 1'b0, 1'b1);
    tick(4);
    chk("ext_rx_word", 0, 32'(last_pop[0]), 32'h96);

    // overflow: 5 words into a 4-deep FIFO with no consumer
    lb[0] = 1;
    rx_ready[0] = 0;
    pop_n = 0;
    for (int i = 0; i < 5; i++) send(0, ovf_words[i]);
    tick(60);
    chk("ovf_set", 0, 32'(ovf[0]), 32'(exp_ovf[0]));
    chk("ovf_literal", 0, 32'(ovf[0]), 32'd1);
    chk("ovf_rx_valid", 0, 32'(rx_valid[0]), 32'd1);
    chk("ovf_head", 0, 32'(rx_data[0]), 32'h11);
    eclr[0] = 1;
    tick(1);
    eclr[0] = 0;
    exp_ovf[0] = 0;
    chk("ovf_clear", 0, 32'(ovf[0]), 32'(exp_ovf[0]));
    rx_ready[0] = 1;
    tick(10);
    chk("ovf_pop_count", 0, 32'(pop_n), 32'd4);
    for (int i = 0; i < 4; i++) chk("ovf_pop_order", 0, 32'(pop_log[i]), 32'(ovf_words[i]));
    chk("ovf_drained", 0, 32'(rx_valid[0]), 32'd0);

    // reset in the middle of the data bits
    send(0, 8'hC3);
    tick(4 * CPB);
    rst_n = 1'b0;
    tx_head[0] = tx_tail[0];
    rx_head[0] = rx_tail[0];
    #1;
    chk("midrst_serial_out", 0, 32'(sout[0]), 32'd1);
    chk("midrst_tx_ready", 0, 32'(tx_ready[0]), 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send(0, 8'h5A);
    tick(60);
    chk("postrst_rx_word", 0, 32'(last_pop[0]), 32'h5A);
    chk("postrst_model_drained", 0, 32'(rx_tail[0] - rx_head[0]), 32'd0);
    chk("postrst_no_errs", 0, 32'(act_ferr[0]), 32'(exp_ferr[0]));

    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
